// File: rtl/fp_operand_master_pkg.sv
// Shared constants and FSM state encoding for the floating-point operand initiator.
package fp_operand_master_pkg;

  localparam logic [31:0] QNAN                   = 32'hFFC0_0000;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT_Z = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/fp_operand_master_if.sv
// Request/response port plus the strobe/ack operand and result channels of an FP unit.
interface fp_operand_master_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;

  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    input  req_valid, op_a, op_b, input_a_ack, input_b_ack, output_z, output_z_stb, resp_ready,
    output req_ready, input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
           resp_valid, resp_data, resp_err
  );

  modport slave (
    output req_valid, op_a, op_b, input_a_ack, input_b_ack, output_z, output_z_stb, resp_ready,
    input  req_ready, input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
           resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/fp_operand_master_hs_timeout_counter.sv
// Per-handshake wait counter; expired is raised on the terminal-count cycle.
module hs_timeout_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] terminal,
  output logic        expired
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable && (count == terminal);

endmodule

// File: rtl/fp_operand_master.sv
// Initiator that feeds two operands to a strobe/ack FP unit and returns its result,
// aborting with a qNaN error response if any single handshake stalls too long.
//
//   state  | meaning
//   IDLE   | ready for a request
//   SEND_A | presenting operand a
//   SEND_B | presenting operand b
//   WAIT_Z | acking for the result
//   RESP   | holding result or timeout error until taken
module fp_operand_master
  import fp_operand_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  fp_operand_master_if.master        bus,
  output logic                       busy
);

  localparam logic [15:0] TERMINAL = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, next_state;
  logic [31:0] a_q, b_q, data_q;
  logic        err_q;
  logic        load_ops, capture_z, abort, cnt_clear, cnt_enable, expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A transfer is tested before expiry so an ack on the terminal cycle still wins.
  always_comb begin
    next_state = state;
    load_ops   = 1'b0;
    capture_z  = 1'b0;
    abort      = 1'b0;
    cnt_clear  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          next_state = ST_SEND_A;
          load_ops   = 1'b1;
          cnt_clear  = 1'b1;
        end
      end
      ST_SEND_A: begin
        if (bus.input_a_ack) begin
          next_state = ST_SEND_B;
          cnt_clear  = 1'b1;
        end else if (expired) begin
          next_state = ST_RESP;
          abort      = 1'b1;
        end
      end
      ST_SEND_B: begin
        if (bus.input_b_ack) begin
          next_state = ST_WAIT_Z;
          cnt_clear  = 1'b1;
        end else if (expired) begin
          next_state = ST_RESP;
          abort      = 1'b1;
        end
      end
      ST_WAIT_Z: begin
        if (bus.output_z_stb) begin
          next_state = ST_RESP;
          capture_z  = 1'b1;
        end else if (expired) begin
          next_state = ST_RESP;
          abort      = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (load_ops) begin
        a_q <= bus.op_a;
        b_q <= bus.op_b;
      end
      if (capture_z) begin
        data_q <= bus.output_z;
        err_q  <= 1'b0;
      end else if (abort) begin
        data_q <= QNAN;
        err_q  <= 1'b1;
      end
    end
  end

  assign cnt_enable = (state == ST_SEND_A) || (state == ST_SEND_B) || (state == ST_WAIT_Z);

  hs_timeout_counter u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (TERMINAL),
    .expired  (expired)
  );

  assign bus.req_ready    = (state == ST_IDLE);
  assign bus.input_a      = a_q;
  assign bus.input_a_stb  = (state == ST_SEND_A);
  assign bus.input_b      = b_q;
  assign bus.input_b_stb  = (state == ST_SEND_B);
  assign bus.output_z_ack = (state == ST_WAIT_Z);
  assign bus.resp_valid   = (state == ST_RESP);
  assign bus.resp_data    = data_q;
  assign bus.resp_err     = err_q;
  assign busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_fp_operand_master.sv
// Bench for fp_operand_master: behavioural strobe/ack responder, directed vector table,
// hand-written reset/back-pressure sequences and randomized delays against a reference model.
module tb_fp_operand_master;

  localparam int          TMO  = 8;
  localparam logic [31:0] QNAN = 32'hFFC0_0000;

  typedef struct {
    logic [31:0] a, b, z;
    int          da, db, dz, hold;
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_lat, exp_xa, exp_xb, exp_xz;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  fp_operand_master_if ifc ();

  fp_operand_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifc.master),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Responder: acks operand k cycles after its strobe rises, returns z after dly_z cycles of ack.
  int          dly_a = 0, dly_b = 0, dly_z = 0;
  logic [31:0] z_value = '0;
  int          a_cnt = 0, b_cnt = 0, z_cnt = 0;
  int          xa = 0, xb = 0, xz = 0;
  logic [31:0] cap_a = '0, cap_b = '0, prev_a = '0, prev_b = '0;
  logic        prev_sa = 1'b0, prev_sb = 1'b0, stab_bad = 1'b0;

  always @(negedge clk) begin
    if (ifc.input_a_stb) begin
      if (prev_sa && ifc.input_a !== prev_a) stab_bad = 1'b1;
      ifc.input_a_ack = (a_cnt == dly_a);
      if (a_cnt == dly_a) begin
        cap_a = ifc.input_a;
        xa++;
      end
      a_cnt++;
    end else begin
      ifc.input_a_ack = 1'b0;
      a_cnt = 0;
    end
    if (ifc.input_b_stb) begin
      if (prev_sb && ifc.input_b !== prev_b) stab_bad = 1'b1;
      ifc.input_b_ack = (b_cnt == dly_b);
      if (b_cnt == dly_b) begin
        cap_b = ifc.input_b;
        xb++;
      end
      b_cnt++;
    end else begin
      ifc.input_b_ack = 1'b0;
      b_cnt = 0;
    end
    ifc.output_z = z_value;
    if (ifc.output_z_ack) begin
      ifc.output_z_stb = (z_cnt == dly_z);
      if (z_cnt == dly_z) xz++;
      z_cnt++;
    end else begin
      ifc.output_z_stb = 1'b0;
      z_cnt = 0;
    end
    prev_sa = ifc.input_a_stb;
    prev_sb = ifc.input_b_stb;
    prev_a  = ifc.input_a;
    prev_b  = ifc.input_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Small positive integer to single-precision bits.
  function automatic logic [31:0] flt(input int unsigned n);
    int          p;
    logic [31:0] m;
    p = 0;
    for (int i = 0; i < 24; i++) if (n[i]) p = i;
    m = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic vec_t mk(input logic [31:0] a, b, z, input int da, db, dz, hold,
                              input logic [31:0] ed, input logic ee,
                              input int lat, na, nb, nz);
    vec_t v;
    v.a = a; v.b = b; v.z = z; v.da = da; v.db = db; v.dz = dz; v.hold = hold;
    v.exp_d = ed; v.exp_e = ee; v.exp_lat = lat;
    v.exp_xa = na; v.exp_xb = nb; v.exp_xz = nz;
    return v;
  endfunction

  // Reference: each handshake either completes within TMO cycles or aborts the request.
  function automatic vec_t predict(input logic [31:0] a, b, z, input int da, db, dz, hold);
    vec_t v;
    int   d[3];
    int   x[3];
    logic aborted;
    d[0] = da; d[1] = db; d[2] = dz;
    x[0] = 0;  x[1] = 0;  x[2] = 0;
    aborted = 1'b0;
    v = mk(a, b, z, da, db, dz, hold, z, 1'b0, 1, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      if (!aborted) begin
        if (d[p] < TMO) begin
          v.exp_lat += d[p] + 1;
          x[p] = 1;
        end else begin
          v.exp_lat += TMO;
          v.exp_d   = QNAN;
          v.exp_e   = 1'b1;
          aborted   = 1'b1;
        end
      end
    end
    v.exp_xa = x[0]; v.exp_xb = x[1]; v.exp_xz = x[2];
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int          sa, sb, sz, n, lat;
    logic [31:0] d;
    logic        e;
    sa = xa; sb = xb; sz = xz;
    dly_a = v.da; dly_b = v.db; dly_z = v.dz; z_value = v.z;
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.op_a = v.a;
    ifc.op_b = v.b;
    n = 0;
    while (!ifc.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " req_ready"}, 32'(ifc.req_ready), 32'd1);
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    ifc.op_a = $urandom;
    ifc.op_b = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ifc.resp_valid && lat < 300);
    d = ifc.resp_data;
    e = ifc.resp_err;
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " resp_data"}, d, v.exp_d);
    chk({tag, " resp_err"}, 32'(e), 32'(v.exp_e));
    chk({tag, " resp_quiet"},
        32'({ifc.input_a_stb, ifc.input_b_stb, ifc.output_z_ack, busy, ifc.req_ready}),
        32'(5'b00010));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk({tag, " hold"}, {ifc.resp_data[31:2], ifc.resp_valid, ifc.req_ready},
          {d[31:2], 1'b1, 1'b0});
    end
    ifc.resp_ready = 1'b1;
    @(negedge clk);
    ifc.resp_ready = 1'b0;
    chk({tag, " back_to_idle"}, 32'({ifc.req_ready, ifc.resp_valid, busy}), 32'(3'b100));
    chk({tag, " a_xfers"}, 32'(xa - sa), 32'(v.exp_xa));
    chk({tag, " b_xfers"}, 32'(xb - sb), 32'(v.exp_xb));
    chk({tag, " z_xfers"}, 32'(xz - sz), 32'(v.exp_xz));
    if (v.exp_xa > 0) chk({tag, " a_bus"}, cap_a, v.a);
    if (v.exp_xb > 0) chk({tag, " b_bus"}, cap_b, v.b);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ctl"},
        32'({ifc.req_ready, busy, ifc.input_a_stb, ifc.input_b_stb, ifc.output_z_ack,
             ifc.resp_valid, ifc.resp_err}), 32'(7'b1000000));
    chk({tag, " input_a"}, ifc.input_a, 32'd0);
    chk({tag, " input_b"}, ifc.input_b, 32'd0);
    chk({tag, " resp_data"}, ifc.resp_data, 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = mk(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 3, 0,
                32'h4040_0000, 1'b0, 7, 1, 1, 1);
    tbl[1] = mk(32'h3FC0_0000, 32'h4010_0000, 32'h4070_0000, 0, 0, 0, 20,
                32'h4070_0000, 1'b0, 4, 1, 1, 1);
    tbl[2] = mk(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 0, 99, 0, 0,
                QNAN, 1'b1, 10, 1, 0, 0);
    tbl[3] = mk(32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 0, 7, 0, 0,
                32'h4080_0000, 1'b0, 11, 1, 1, 1);
    tbl[4] = mk(32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D, 99, 0, 0, 2,
                QNAN, 1'b1, 9, 0, 0, 0);
    tbl[5] = mk(32'h4100_0000, 32'h4080_0000, 32'h4000_0000, 1, 2, 99, 0,
                QNAN, 1'b1, 14, 1, 1, 0);
    tbl[6] = mk(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 2, 0, 7, 1,
                32'h4080_0000, 1'b0, 13, 1, 1, 1);
    tbl[7] = mk(32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 7, 0, 0, 0,
                32'h3F80_0000, 1'b0, 11, 1, 1, 1);

    rst = 1'b0;
    ifc.req_valid  = 1'b0;
    ifc.resp_ready = 1'b0;
    ifc.op_a = '0;
    ifc.op_b = '0;
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

    for (int k = 1; k <= 10; k++)
      run_vec($sformatf("b2b%0d", k),
              predict(flt(k), flt(2), flt(2 * k), 0, 0, 0, 0));

    // Reset pulse while waiting for a result aborts with no response.
    dly_a = 0; dly_b = 0; dly_z = 1000; z_value = 32'h4444_4444;
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.op_a = 32'h4120_0000;
    ifc.op_b = 32'h4120_0000;
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!ifc.output_z_ack && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("reached_wait_z", 32'(ifc.output_z_ack), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    chk_reset_outputs("mid_reset_hold");
    rst = 1'b1;
    run_vec("after_reset", mk(32'h4100_0000, 32'h4080_0000, 32'h4000_0000, 0, 0, 1, 0,
                               32'h4000_0000, 1'b0, 5, 1, 1, 1));

    for (int i = 0; i < 40; i++)
      run_vec($sformatf("rnd%0d", i),
              predict($urandom, $urandom, $urandom,
                      $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                      $urandom_range(0, 3)));

    chk("bus_stable_under_strobe", 32'(stab_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_operand_master.md
FP_OPERAND_MASTER -- requirements
Module: fp_operand_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, max cycles spent waiting in any one handshake state before abort (legal range 2..65535).
REQ-002 One clock; reset is asynchronous and active-low (ports clk, rst; the polarity and synchronicity here are fixed).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  request (op_a, op_b) present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 op_a, op_b  in  32 each  IEEE-754 single-precision operands.
REQ-008 input_a / input_b  out  32 each  operand bus to the arithmetic unit.
REQ-009 input_a_stb / input_b_stb  out  1 each  operand strobes; input_a_ack / input_b_ack  in  1 each  responder acks.
REQ-010 output_z  in  32  unit result; output_z_stb  in  1  result strobe; output_z_ack  out  1  result ack.
REQ-011 resp_valid  out  1; resp_ready  in  1; resp_data  out  32  result; resp_err  out  1  timeout abort flag.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
REQ-014 IDLE: req_ready=1; on req_valid&&req_ready, register op_a/op_b and go to SEND_A next cycle.
REQ-015 SEND_A: input_a=registered op_a, input_a_stb=1; at the edge where input_a_stb&&input_a_ack, go to SEND_B; input_a_stb is 0 in the following cycle.
REQ-016 SEND_B: same as SEND_A with the b signals; on transfer, go to WAIT_Z.
REQ-017 Operand buses hold their value while the strobe is high, and change only when the strobe is low.
REQ-018 WAIT_Z: output_z_ack=1; at the edge where output_z_stb&&output_z_ack, capture output_z into resp_data, clear resp_err, go to RESP; output_z_ack is 0 in the following cycle.
REQ-019 Exactly one operand a, one operand b and one result are transferred per request. The block never holds a strobe or ack high for two transfer edges.
REQ-020 RESP: resp_valid=1; resp_data and resp_err are stable until resp_ready; on resp_valid&&resp_ready, go to IDLE (req_ready=1 the next cycle; no bypass from RESP to SEND_A).
REQ-021 Timeout counter: 16-bit, cleared on entry to SEND_A, SEND_B and WAIT_Z, and incremented on every cycle spent in those states.
REQ-022 When the counter equals TIMEOUT_CYCLES-1 and no transfer occurs on that edge: drop all strobes and acks, resp_data=32'hFFC00000 (qNaN), resp_err=1, go to RESP.
REQ-023 If a transfer and a timeout occur on the same edge, the transfer wins.
REQ-024 Minimum latency from request acceptance to resp_valid, with a zero-wait responder: 4 cycles, plus the responder's compute time.
REQ-025 req_valid is ignored outside IDLE. Handshake inputs are ignored outside their own state.

Reset
REQ-026 While rst=0: state=IDLE, req_ready=1, and every other output (all strobes, output_z_ack, resp_valid, resp_err, busy, input_a, input_b, resp_data, counter) is 0.
REQ-027 Reset asserted mid-transaction aborts it immediately, with no response issued. The first request after reset is handled normally.

Structure
REQ-028 Shared defines header holds: the qNaN constant 32'hFFC00000, the default TIMEOUT_CYCLES, and the FSM state encodings (3-bit).
REQ-029 One sub-module, hs_timeout_counter: clear, enable and terminal-count inputs; expired output.
REQ-030 fp_operand_master is a drop-in initiator for the existing adder, multiplier and divider_newton units, and instantiates none of them.

Verification
REQ-031 6.0/2.0 through divider_newton: op_a=0x40C00000, op_b=0x40000000 -> resp_data=0x40400000, resp_err=0.
REQ-032 Adder as responder: 1.5+2.25 (0x3FC00000, 0x40100000) -> resp_data=0x40700000. Each of input_a_stb, input_b_stb and output_z_ack is high for exactly one transfer edge.
REQ-033 Responder never acks b, TIMEOUT_CYCLES=8 -> resp_valid occurs 8 cycles after SEND_B entry, resp_data=0xFFC00000, resp_err=1, input_b_stb=0.
REQ-034 Ack arrives on the counter's terminal cycle -> transfer accepted, no error.
REQ-035 resp_ready held low for 20 cycles -> resp_data stable, req_ready=0. Then 10 back-to-back requests (1.0*k, 2.0) -> 10 correct results in order.
REQ-036 rst pulsed low while in WAIT_Z -> all outputs are at reset values asynchronously; the next request 8.0/4.0 returns 0x40000000.
